// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_responder
// Brief    : 256 x 8 data memory on a shared bidirectional bus, serving
//            read / write / clear-all commands from the control unit.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_responder #(
  parameter bit         CLEAR_ENABLE = 1'b1,
  parameter logic [7:0] CLEAR_VALUE  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd_memory,
  input  logic [7:0] addr_memory,
  inout  wire  [7:0] data_memory,
  output logic       busy,
  output logic       err
);

  localparam logic [7:0] C_CMD_READ  = 8'h00;
  localparam logic [7:0] C_CMD_WRITE = 8'h01;
  localparam logic [7:0] C_CMD_CLEAR = 8'h02;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [7:0] r_mem [0:255];
  logic [7:0] r_rdata;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] r_prev_cmd;
  logic       r_prev_valid;
  logic       r_err;

  logic       w_mem_we;
  logic [7:0] w_mem_waddr;
  logic [7:0] w_mem_wdata;
  logic       w_rd_load;
  logic       w_err_set;
  logic       w_clear_edge;
  logic       w_drive;

  // Clear-all needs a genuine transition into 8'h02; the valid bit keeps a
  // command already parked at 8'h02 across reset from starting a sweep.
  assign w_clear_edge = r_prev_valid && (r_prev_cmd != C_CMD_CLEAR);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mem_we    = 1'b0;
    w_mem_waddr = addr_memory;
    w_mem_wdata = data_memory;
    w_rd_load   = 1'b0;
    w_err_set   = 1'b0;

    case (r_state)
      S_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_waddr = r_cnt;
        w_mem_wdata = CLEAR_VALUE;
        w_cnt_nxt   = r_cnt + 8'd1;
        if (r_cnt == 8'hFF) begin
          w_state_nxt = S_IDLE;
        end
        if (cmd_memory != C_CMD_CLEAR) begin
          w_err_set = 1'b1;
        end
      end

      default: begin
        case (cmd_memory)
          C_CMD_READ: begin
            w_rd_load   = 1'b1;
            w_state_nxt = S_READ;
          end
          C_CMD_WRITE: begin
            w_mem_we    = 1'b1;
            w_state_nxt = S_IDLE;
          end
          C_CMD_CLEAR: begin
            w_state_nxt = S_IDLE;
            if (!CLEAR_ENABLE) begin
              w_err_set = 1'b1;
            end else if (w_clear_edge) begin
              w_state_nxt = S_CLEAR;
              w_cnt_nxt   = 8'h00;
            end
          end
          default: begin
            w_err_set   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'h00;
      r_rdata      <= 8'h00;
      r_prev_cmd   <= 8'h00;
      r_prev_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_prev_cmd   <= cmd_memory;
      r_prev_valid <= 1'b1;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_rd_load) begin
        r_rdata <= r_mem[addr_memory];
      end
    end
  end

  // Storage is deliberately outside the reset domain; rst only blocks writes.
  always_ff @(posedge clk) begin
    if (w_mem_we && !rst) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  assign w_drive     = (r_state == S_READ) && (cmd_memory == C_CMD_READ);
  assign data_memory = w_drive ? r_rdata : 8'hzz;
  assign busy        = (r_state == S_CLEAR);
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_responder
// Brief    : Scoreboard bench for data_memory_responder with a behavioural
//            memory model and randomized read/write traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_responder;

  logic       clk;
  logic       rst;
  logic [7:0] cmd;
  logic [7:0] addr;
  logic [7:0] wd;
  wire  [7:0] data_memory;
  logic       busy;
  logic       err;

  data_memory_responder dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_memory (cmd),
    .addr_memory(addr),
    .data_memory(data_memory),
    .busy       (busy),
    .err        (err)
  );

  // The bench plays the control unit: it owns the bus only for writes.
  assign data_memory = (cmd == 8'h01) ? wd : 8'hzz;

  wire bus_released = (data_memory === 8'hzz);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rel;
    logic [7:0] bus;
    logic       busy;
    logic       err;
  } exp_t;

  exp_t q_comb[$];
  exp_t q_edge[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: storage array plus "what the last edge did".
  logic [7:0] m_mem [256];
  logic [7:0] m_rdata;
  logic       m_reading;
  logic       m_err;
  int         m_left;
  int         m_pos;
  int         m_prev;

  function automatic void model_reset();
    m_rdata   = 8'h00;
    m_reading = 1'b0;
    m_err     = 1'b0;
    m_left    = 0;
    m_pos     = 0;
    m_prev    = -1;
  endfunction

  function automatic void model_edge(input logic [7:0] c, input logic [7:0] a,
                                     input logic [7:0] d);
    if (m_left > 0) begin
      if (c != 8'h02) m_err = 1'b1;
      m_mem[m_pos] = 8'h00;
      m_pos        = m_pos + 1;
      m_left       = m_left - 1;
      m_reading    = 1'b0;
    end else if (c == 8'h00) begin
      m_rdata   = m_mem[a];
      m_reading = 1'b1;
    end else if (c == 8'h01) begin
      m_mem[a]  = d;
      m_reading = 1'b0;
    end else if (c == 8'h02) begin
      m_reading = 1'b0;
      if (m_prev >= 0 && m_prev != 2) begin
        m_left = 256;
        m_pos  = 0;
      end
    end else begin
      m_reading = 1'b0;
      m_err     = 1'b1;
    end
    m_prev = int'(c);
  endfunction

  function automatic exp_t make_exp(input logic [7:0] c, input logic [7:0] d);
    exp_t e;
    e.rel  = 1'b1;
    e.bus  = 8'h00;
    e.busy = (m_left > 0);
    e.err  = m_err;
    if (c == 8'h01) begin
      e.rel = 1'b0;
      e.bus = d;
    end else if (c == 8'h00 && m_reading && m_left == 0) begin
      e.rel = 1'b0;
      e.bus = m_rdata;
    end
    return e;
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
  endtask

  task automatic compare(input exp_t e, input string when);
    if (e.rel) check8({when, "_bus_released"}, {7'd0, bus_released}, 8'd1);
    else       check8({when, "_bus"}, data_memory, e.bus);
    check8({when, "_busy"}, {7'd0, busy}, {7'd0, e.busy});
    check8({when, "_err"},  {7'd0, err},  {7'd0, e.err});
  endtask

  // Monitors: bus right after inputs change, and state right after each edge.
  initial forever begin
    @(negedge clk);
    #1;
    if (q_comb.size() > 0) compare(q_comb.pop_front(), "comb");
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (q_edge.size() > 0) compare(q_edge.pop_front(), "edge");
  end

  task automatic step(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    rst  = 1'b0;
    cmd  = c;
    addr = a;
    wd   = d;
    q_comb.push_back(make_exp(c, d));
    model_edge(c, a, d);
    q_edge.push_back(make_exp(c, d));
  endtask

  task automatic do_reset(input logic [7:0] c);
    @(negedge clk);
    rst  = 1'b1;
    cmd  = c;
    addr = 8'h00;
    wd   = 8'h00;
    model_reset();
    q_comb.push_back(make_exp(c, 8'h00));
    q_edge.push_back(make_exp(c, 8'h00));
  endtask

  task automatic random_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      step(8'($urandom_range(0, 1)), a, 8'($urandom));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks so far %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst  = 1'b1;
    cmd  = 8'h00;
    addr = 8'h00;
    wd   = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset(8'h00);

    // Give every location a known value so any later read is predictable.
    for (int a = 0; a < 256; a++) step(8'h01, 8'(a), 8'($urandom));

    // Write then read back, then hold the read and turn it into a write.
    step(8'h01, 8'h10, 8'hA5);
    step(8'h00, 8'h10, 8'h00);
    step(8'h00, 8'h10, 8'h00);
    step(8'h01, 8'h10, 8'h5A);
    step(8'h00, 8'h10, 8'h00);
    step(8'h00, 8'h11, 8'h00);
    step(8'h00, 8'h10, 8'h00);

    random_traffic(150);

    // Full sweep triggered by a single transition, boundaries 0 and 255.
    step(8'h01, 8'h00, 8'h3C);
    step(8'h01, 8'hFF, 8'h3C);
    step(8'h00, 8'h00, 8'h00);
    repeat (258) step(8'h02, 8'h00, 8'h00);
    step(8'h00, 8'h00, 8'h00);
    step(8'h00, 8'hFF, 8'h00);
    step(8'h00, 8'hFF, 8'h00);

    // A long-held clear command sweeps exactly once.
    step(8'h01, 8'h80, 8'h66);
    step(8'h00, 8'h80, 8'h00);
    repeat (300) step(8'h02, 8'h00, 8'h00);
    step(8'h00, 8'h80, 8'h00);

    // Unsupported command, then read and write attempts during a sweep.
    step(8'h01, 8'h20, 8'hC3);
    step(8'h07, 8'h20, 8'h11);
    step(8'h00, 8'h20, 8'h00);
    repeat (5) step(8'h02, 8'h00, 8'h00);
    step(8'h00, 8'h20, 8'h00);
    step(8'h01, 8'h30, 8'hEE);
    repeat (260) step(8'h02, 8'h00, 8'h00);
    step(8'h00, 8'h30, 8'h00);
    step(8'h00, 8'h20, 8'h00);

    // Abort a sweep with reset after 100 locations have been cleared.
    step(8'h01, 8'd50,  8'h77);
    step(8'h01, 8'd200, 8'h99);
    step(8'h00, 8'h00,  8'h00);
    repeat (101) step(8'h02, 8'h00, 8'h00);
    do_reset(8'h00);
    step(8'h00, 8'd50,  8'h00);
    step(8'h00, 8'd200, 8'h00);
    step(8'h00, 8'd99,  8'h00);
    step(8'h00, 8'd100, 8'h00);

    // A clear command already present when reset releases must not sweep.
    do_reset(8'h02);
    repeat (3) step(8'h02, 8'h00, 8'h00);
    step(8'h00, 8'd200, 8'h00);

    random_traffic(150);

    @(posedge clk);
    #3;
    n_checks++;
    if (q_comb.size() == 0 && q_edge.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d/%0d pending, expected 0/0", q_comb.size(), q_edge.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
